// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: widths, ResultSrc encodings and the
// decode control bundle carried from D into E.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_CTRL_W = 3;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  alu_src;
        logic [1:0]            result_src;
        logic [ALU_CTRL_W-1:0] alu_control;
    } ctrl_t;

    localparam ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detection: the instruction in E is a load whose destination
// is read by the instruction in D, so D must wait one cycle.
module hazard_detect_unit
    import rv_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [1:0]            result_src_e,
    output logic                  lw_stall
);

    assign lw_stall = (result_src_e == RES_MEM) && (rd_e != '0) &&
                      ((rd_e == rs1) || (rd_e == rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, x0 forcing, load-use stall
// generation and a saturating count of inserted bubbles.
module id_ex_stage
    import rv_pkg::*;
#(
    parameter int XLEN         = rv_pkg::XLEN,
    parameter int BUBBLE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             InstrD,
    input  logic [XLEN-1:0]         PCD,
    input  logic [XLEN-1:0]         PCPlus4D,
    input  logic [XLEN-1:0]         RD1D,
    input  logic [XLEN-1:0]         RD2D,
    input  logic [XLEN-1:0]         ImmExtD,
    input  logic                    RegWriteD,
    input  logic                    MemWriteD,
    input  logic                    BranchD,
    input  logic                    JumpD,
    input  logic                    ALUSrcD,
    input  logic [1:0]              ResultSrcD,
    input  logic [ALU_CTRL_W-1:0]   ALUControlD,
    input  logic                    RegWriteW,
    input  logic [REG_ADDR_W-1:0]   RdW,
    input  logic [XLEN-1:0]         ResultW,
    input  logic                    FlushE,
    output logic [REG_ADDR_W-1:0]   A1,
    output logic [REG_ADDR_W-1:0]   A2,
    output logic                    StallF,
    output logic                    StallD,
    output logic                    RegWriteE,
    output logic                    MemWriteE,
    output logic                    BranchE,
    output logic                    JumpE,
    output logic                    ALUSrcE,
    output logic [1:0]              ResultSrcE,
    output logic [ALU_CTRL_W-1:0]   ALUControlE,
    output logic [XLEN-1:0]         RD1E,
    output logic [XLEN-1:0]         RD2E,
    output logic [XLEN-1:0]         ImmExtE,
    output logic [XLEN-1:0]         PCE,
    output logic [XLEN-1:0]         PCPlus4E,
    output logic [REG_ADDR_W-1:0]   Rs1E,
    output logic [REG_ADDR_W-1:0]   Rs2E,
    output logic [REG_ADDR_W-1:0]   RdE,
    output logic [BUBBLE_CNT_W-1:0] BubbleCount
);

    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic                  lw_stall;
    logic                  bubble;
    ctrl_t                 ctrl_d, ctrl_e;
    logic [XLEN-1:0]       rd1_fwd, rd2_fwd;
    logic                  unused_instr_bits;

    assign rs1 = InstrD[19:15];
    assign rs2 = InstrD[24:20];
    assign rd  = InstrD[11:7];
    assign A1  = rs1;
    assign A2  = rs2;

    // Opcode/funct fields are decoded upstream; only register fields matter here.
    assign unused_instr_bits = &{InstrD[31:25], InstrD[14:12], InstrD[6:0]};

    hazard_detect_unit u_hazard (
        .rs1          (rs1),
        .rs2          (rs2),
        .rd_e         (RdE),
        .result_src_e (ctrl_e.result_src),
        .lw_stall     (lw_stall)
    );

    assign StallF = lw_stall & rst;
    assign StallD = lw_stall & rst;
    assign bubble = FlushE | lw_stall;

    assign ctrl_d = '{reg_write:   RegWriteD,
                      mem_write:   MemWriteD,
                      branch:      BranchD,
                      jump:        JumpD,
                      alu_src:     ALUSrcD,
                      result_src:  ResultSrcD,
                      alu_control: ALUControlD};

    // The register file writes on the same edge, so a same-cycle read is stale;
    // x0 wins over the bypass.
    always_comb begin
        rd1_fwd = RD1D;
        rd2_fwd = RD2D;
        if (RegWriteW && RdW != '0 && RdW == rs1) rd1_fwd = ResultW;
        if (RegWriteW && RdW != '0 && RdW == rs2) rd2_fwd = ResultW;
        if (rs1 == '0) rd1_fwd = '0;
        if (rs2 == '0) rd2_fwd = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_e   <= NOP_CTRL;
            RD1E     <= '0;
            RD2E     <= '0;
            ImmExtE  <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
        end else if (bubble) begin
            ctrl_e   <= NOP_CTRL;
            RD1E     <= '0;
            RD2E     <= '0;
            ImmExtE  <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
        end else begin
            ctrl_e   <= ctrl_d;
            RD1E     <= rd1_fwd;
            RD2E     <= rd2_fwd;
            ImmExtE  <= ImmExtD;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            Rs1E     <= rs1;
            Rs2E     <= rs2;
            RdE      <= rd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            BubbleCount <= '0;
        else if (bubble && BubbleCount != '1)
            BubbleCount <= BubbleCount + 1'b1;
    end

    assign RegWriteE   = ctrl_e.reg_write;
    assign MemWriteE   = ctrl_e.mem_write;
    assign BranchE     = ctrl_e.branch;
    assign JumpE       = ctrl_e.jump;
    assign ALUSrcE     = ctrl_e.alu_src;
    assign ResultSrcE  = ctrl_e.result_src;
    assign ALUControlE = ctrl_e.alu_control;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a 4-bit bubble counter so saturation
// is reachable in a few cycles.
module tb_id_ex_stage;
    import rv_pkg::*;

    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     InstrD, PCD, PCPlus4D, RD1D, RD2D, ImmExtD, ResultW;
    logic            RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD;
    logic [1:0]      ResultSrcD;
    logic [2:0]      ALUControlD;
    logic            RegWriteW, FlushE;
    logic [4:0]      RdW;
    logic [4:0]      A1, A2, Rs1E, Rs2E, RdE;
    logic            StallF, StallD;
    logic            RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      ALUControlE;
    logic [31:0]     RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [CW-1:0]   BubbleCount;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .BUBBLE_CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD),
        .JumpD(JumpD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
        .ALUControlD(ALUControlD), .RegWriteW(RegWriteW), .RdW(RdW),
        .ResultW(ResultW), .FlushE(FlushE), .A1(A1), .A2(A2),
        .StallF(StallF), .StallD(StallD), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .BubbleCount(BubbleCount)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
        return {7'b0, s2, s1, 3'b0, d, 7'b0110011};
    endfunction

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        InstrD = '0; PCD = '0; PCPlus4D = '0; RD1D = '0; RD2D = '0; ImmExtD = '0;
        RegWriteD = 0; MemWriteD = 0; BranchD = 0; JumpD = 0; ALUSrcD = 0;
        ResultSrcD = RES_ALU; ALUControlD = '0;
        RegWriteW = 0; RdW = '0; ResultW = '0; FlushE = 0;
        #3;
        chk("rst_rd1e", RD1E, 0);
        chk("rst_regwe", RegWriteE, 0);
        chk("rst_cnt", BubbleCount, 0);
        chk("rst_stalld", StallD, 0);
        step();
        rst = 1'b1;

        // Plain flush
        FlushE = 1; step(); exp_cnt++;
        chk("flush_cnt", BubbleCount, exp_cnt);
        FlushE = 0;

        // Capture
        InstrD = mk(5, 6, 3); RD1D = 32'd6; RD2D = 32'd10; ImmExtD = 32'd4;
        PCD = 32'h100; PCPlus4D = 32'h104; RegWriteD = 1; ALUControlD = 3'b010;
        ResultSrcD = RES_ALU; ALUSrcD = 1; BranchD = 1; JumpD = 1;
        #1;
        chk("cap_a1", A1, 5);
        chk("cap_a2", A2, 6);
        chk("cap_stalld_pre", StallD, 0);
        step();
        chk("cap_rd1e", RD1E, 6);
        chk("cap_rd2e", RD2E, 10);
        chk("cap_imm", ImmExtE, 4);
        chk("cap_rs1e", Rs1E, 5);
        chk("cap_rs2e", Rs2E, 6);
        chk("cap_rde", RdE, 3);
        chk("cap_pce", PCE, 32'h100);
        chk("cap_pc4e", PCPlus4E, 32'h104);
        chk("cap_ctrl", {RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, ResultSrcE, ALUControlE},
            {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 3'b010});
        chk("cap_stalld", StallD, 0);
        BranchD = 0; JumpD = 0; ALUSrcD = 0;

        // Load into E, dependent add in D
        InstrD = mk(2, 0, 7); ResultSrcD = RES_MEM; RegWriteD = 1; ALUSrcD = 1;
        step();
        chk("lw_rse", ResultSrcE, RES_MEM);
        chk("lw_rde", RdE, 7);
        InstrD = mk(7, 8, 9); ResultSrcD = RES_ALU; ALUSrcD = 0; MemWriteD = 1;
        RD1D = 32'h77; RD2D = 32'h88;
        #1;
        chk("lu_stallf", StallF, 1);
        chk("lu_stalld", StallD, 1);
        step(); exp_cnt++;
        chk("lu_regwe", RegWriteE, 0);
        chk("lu_memwe", MemWriteE, 0);
        chk("lu_rde", RdE, 0);
        chk("lu_rd1e", RD1E, 0);
        chk("lu_cnt", BubbleCount, exp_cnt);
        chk("lu_stalld_after", StallD, 0);
        step();
        chk("lu_replay_rde", RdE, 9);
        chk("lu_replay_rd1e", RD1E, 32'h77);
        chk("lu_replay_memwe", MemWriteE, 1);
        MemWriteD = 0;

        // Load-use via rs2
        InstrD = mk(1, 0, 12); ResultSrcD = RES_MEM; step();
        InstrD = mk(3, 12, 13); ResultSrcD = RES_ALU; #1;
        chk("lu2_stalld", StallD, 1);
        step(); exp_cnt++;
        chk("lu2_cnt", BubbleCount, exp_cnt);
        step();

        // WB bypass on rs2
        InstrD = mk(1, 9, 4); RD1D = 32'h11; RD2D = 32'h0;
        RegWriteW = 1; RdW = 9; ResultW = 32'h1234;
        step();
        chk("byp_rd2e", RD2E, 32'h1234);
        chk("byp_rd1e_nohit", RD1E, 32'h11);
        RdW = 0; step();
        chk("byp_rdw0", RD2E, 0);
        RdW = 1; ResultW = 32'h55; step();
        chk("byp_rd1e", RD1E, 32'h55);
        RegWriteW = 0; step();
        chk("byp_off", RD1E, 32'h11);

        // x0 wins over data and bypass
        InstrD = mk(0, 0, 4); RD1D = 32'hFFFF_FFFF; RD2D = 32'hFFFF_FFFF;
        RegWriteW = 1; RdW = 0; ResultW = 32'hABC; step();
        chk("x0_rd1e", RD1E, 0);
        chk("x0_rd2e", RD2E, 0);
        RegWriteW = 0;

        // Flush together with load-use: one bubble
        InstrD = mk(2, 0, 7); ResultSrcD = RES_MEM; step();
        InstrD = mk(7, 7, 8); ResultSrcD = RES_ALU; FlushE = 1; #1;
        chk("fs_stalld", StallD, 1);
        step(); exp_cnt++;
        chk("fs_cnt", BubbleCount, exp_cnt);
        chk("fs_regwe", RegWriteE, 0);
        FlushE = 0;

        // Mid-run asynchronous reset
        InstrD = mk(3, 4, 5); RD1D = 32'hDEADBEEF; RegWriteD = 1; step();
        chk("pre_rst_rd1e", RD1E, 32'hDEADBEEF);
        #2; rst = 1'b0; #1;
        chk("mrst_regwe", RegWriteE, 0);
        chk("mrst_rd1e", RD1E, 0);
        chk("mrst_rde", RdE, 0);
        chk("mrst_cnt", BubbleCount, 0);
        exp_cnt = 0;
        step();
        rst = 1'b1;

        // Saturation
        FlushE = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (exp_cnt < 15) exp_cnt++;
        end
        chk("sat_cnt", BubbleCount, exp_cnt);
        chk("sat_15", exp_cnt, 15);
        FlushE = 0;
        step();
        chk("sat_hold", BubbleCount, 15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute boundary of the pipelined RV32I core, directly downstream of the register file.
- Registers the register-file read data (RD1/RD2), immediate, PC values, register addresses and decode control into the E stage.
- Applies a write-back-to-decode bypass, forces x0 reads to zero, and detects load-use hazards to drive StallF/StallD.
- Inserts bubbles on stall or flush and counts them.

Parameters:
- XLEN, 32, datapath width.
- BUBBLE_CNT_W, 16, width of the bubble performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- InstrD  in  32  decode-stage instruction; Rs1D=[19:15], Rs2D=[24:20], RdD=[11:7].
- PCD  in  XLEN  decode PC.
- PCPlus4D  in  XLEN  decode PC+4.
- RD1D  in  XLEN  register-file read port 1 data.
- RD2D  in  XLEN  register-file read port 2 data.
- ImmExtD  in  XLEN  extended immediate.
- RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD  in  1 each  decode control.
- ResultSrcD  in  2  00 ALU, 01 memory, 10 PC+4.
- ALUControlD  in  3  ALU opcode.
- RegWriteW  in  1  write-back enable.
- RdW  in  5  write-back destination.
- ResultW  in  XLEN  write-back data.
- FlushE  in  1  branch/jump taken; squash the D-stage instruction.
- A1, A2  out  5  register-file read addresses (Rs1D, Rs2D, combinational).
- StallF, StallD  out  1  load-use stall requests (combinational).
- RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE  out  1 each  registered control.
- ResultSrcE  out  2  registered.
- ALUControlE  out  3  registered.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN  registered data.
- Rs1E, Rs2E, RdE  out  5  registered addresses, used by the forwarding unit.
- BubbleCount  out  BUBBLE_CNT_W  number of bubbles inserted, saturating.

Behaviour:
- Reset: rst low asynchronously clears every registered output and BubbleCount to 0. The E stage then holds a NOP. Reset mid-stream discards the in-flight instruction.
- Load-use hazard: lwStall = ResultSrcE==01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - StallF = StallD = lwStall, combinational.
  - During reset (rst low) both are 0.
- Bubble: on a rising edge with FlushE=1 or lwStall=1:
  - All E control bits clear to 0, and Rs1E/Rs2E/RdE clear to 0.
  - Data outputs load 0.
  - BubbleCount increments, saturating at all-ones.
- Simultaneous flush and stall produce exactly one bubble and one count increment.
- Capture: otherwise, all E registers load their D-stage values. Latency is 1 cycle.
- WB bypass: register-file writes happen on the edge, so same-cycle reads return the old value. Therefore:
  - RD1E <= (RegWriteW && RdW!=0 && RdW==Rs1D) ? ResultW : RD1D.
  - RD2E follows the same rule with Rs2D.
- x0: if Rs1D==0, RD1E <= 0 regardless of RD1D or the bypass. Same for Rs2D and RD2E.
- Stalled D instruction: StallD holds the D register upstream, so the same instruction is re-presented and captured on the following edge, once RdE no longer matches.
- No internal FSM beyond the bubble/capture choice. All arithmetic on BubbleCount is unsigned with saturation.

Decomposition:
- Shared package rv_pkg:
  - XLEN and REG_ADDR_W=5.
  - ResultSrc encodings RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10.
  - ALUControl width constant.
  - NOP control bundle constant (all zero).
- Sub-module hazard_detect_unit: combinational lwStall generation from Rs1D, Rs2D, RdE and ResultSrcE. Instantiated once.

Test Plan:
- Reset: rst=0 mid-run with RegWriteD=1, RD1D=0xDEADBEEF -> all E outputs 0 immediately, before any clock edge; BubbleCount=0.
- Capture: Rs1D=5, RD1D=6, Rs2D=6, RD2D=10, ImmExtD=4, ResultSrcD=00 -> after 1 edge RD1E=6, RD2E=10, ImmExtE=4, Rs1E=5, StallD=0.
- Load-use: E holds a lw with RdE=7, ResultSrcE=01; D has add with Rs1D=7 -> StallF=StallD=1; next edge RegWriteE=0, MemWriteE=0, RdE=0; BubbleCount=1.
- WB bypass: RegWriteW=1, RdW=9, ResultW=0x1234, Rs2D=9, RD2D=0 -> RD2E=0x1234. Repeat with RdW=0 -> RD2E=0.
- x0 and flush: Rs1D=0 with RD1D=0xFFFFFFFF -> RD1E=0. FlushE=1 together with lwStall=1 -> single bubble, BubbleCount increments by exactly 1.
- Saturation: with BUBBLE_CNT_W=4, hold FlushE=1 for 20 cycles -> BubbleCount stops at 15.
